// File: rtl/video_crop_pkg.sv
// Shared video definitions: crop FSM states and sync polarities.
// Imported by the crop top and the reusable sync edge detector.
package video_crop_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_VBLANK,
    S_HBLANK,
    S_LINE
  } state_t;

  localparam logic HS_ACTIVE = 1'b0;
  localparam logic VS_ACTIVE = 1'b1;

endpackage

// File: rtl/video_crop_sync_edge.sv
// video_sync_edge: registers hs/vs and produces single-cycle rise/fall pulses.
// Shared by the crop, binning and scaler stages.
module video_sync_edge
  import video_crop_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hs,
  input  logic vs,
  output logic hs_rise,
  output logic hs_fall,
  output logic vs_rise,
  output logic vs_fall
);

  logic hs_q;
  logic vs_q;

  // Reset to the blanking levels so no edge is reported straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q <= ~HS_ACTIVE;
      vs_q <= ~VS_ACTIVE;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
    end
  end

  assign hs_rise = hs & ~hs_q;
  assign hs_fall = ~hs & hs_q;
  assign vs_rise = vs & ~vs_q;
  assign vs_fall = ~vs & vs_q;

endmodule

// File: rtl/video_crop.sv
// video_crop: forwards a rectangular window of a de/hs/vs stream, 1-cycle latency.
// Optional status outputs (in_width, in_height, crop_err) under VIDEO_CROP_STATUS_EN.
module video_crop
  import video_crop_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 8,
  parameter int LINE_SIZE_MAX   = 1024,
  parameter int FRAME_LINES_MAX = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               bypass,
  input  logic [$clog2(LINE_SIZE_MAX)-1:0]   crop_x_start,
  input  logic [$clog2(LINE_SIZE_MAX):0]     crop_x_size,
  input  logic [$clog2(FRAME_LINES_MAX)-1:0] crop_y_start,
  input  logic [$clog2(FRAME_LINES_MAX):0]   crop_y_size,
  input  logic [PIXEL_WIDTH-1:0]             di_i,
  input  logic                               de_i,
  input  logic                               hs_i,
  input  logic                               vs_i,
  output logic [PIXEL_WIDTH-1:0]             do_o,
  output logic                               de_o,
  output logic                               hs_o,
  output logic                               vs_o
`ifdef VIDEO_CROP_STATUS_EN
  ,
  output logic [$clog2(LINE_SIZE_MAX)-1:0]   in_width,
  output logic [$clog2(FRAME_LINES_MAX)-1:0] in_height,
  output logic                               crop_err
`endif
);

  localparam int XW = $clog2(LINE_SIZE_MAX);
  localparam int YW = $clog2(FRAME_LINES_MAX);
  localparam logic [XW-1:0] PIX_MAX  = XW'(LINE_SIZE_MAX - 1);
  localparam logic [YW-1:0] LINE_MAX = YW'(FRAME_LINES_MAX - 1);

  state_t state, state_nx;

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  logic          bypass_q;
  logic [XW-1:0] x_start_q;
  logic [XW:0]   x_size_q;
  logic [YW-1:0] y_start_q;
  logic [YW:0]   y_size_q;

  logic [XW-1:0] pix_cnt;
  logic [YW-1:0] line_cnt;

  logic          cfg_load;
  logic          in_frame;
  logic          line_active;
  logic [XW-1:0] pix_idx;
  logic [XW+1:0] x_end;
  logic [YW+1:0] y_end;
  logic          line_in_win;
  logic          pix_in_win;
  logic          byp;

  video_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .hs      (hs_i),
    .vs      (vs_i),
    .hs_rise (hs_rise),
    .hs_fall (hs_fall),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_WAIT;
    else      state <= state_nx;
  end

  // Outside S_WAIT, vs can only drop through a falling edge, so vs_fall covers every exit.
  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:   if (vs_i != VS_ACTIVE) state_nx = S_VBLANK;
      S_VBLANK: if (vs_rise)           state_nx = S_HBLANK;
      S_HBLANK: if (hs_fall)           state_nx = S_LINE;
      S_LINE:   if (hs_rise)           state_nx = S_HBLANK;
      default:                         state_nx = S_WAIT;
    endcase
    if (state != S_WAIT && vs_fall) state_nx = S_VBLANK;
  end

  assign cfg_load = (state == S_VBLANK) && vs_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bypass_q  <= 1'b0;
      x_start_q <= '0;
      x_size_q  <= '0;
      y_start_q <= '0;
      y_size_q  <= '0;
    end else if (cfg_load) begin
      bypass_q  <= bypass;
      x_start_q <= crop_x_start;
      x_size_q  <= crop_x_size;
      y_start_q <= crop_y_start;
      y_size_q  <= crop_y_size;
    end
  end

  // A pixel arriving on the hs falling cycle is pixel 0 of the new line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (state == S_HBLANK && hs_fall)
        pix_cnt <= {{(XW-1){1'b0}}, de_i};
      else if (state == S_LINE && de_i && pix_cnt != PIX_MAX)
        pix_cnt <= pix_cnt + XW'(1);

      if (cfg_load)
        line_cnt <= '0;
      else if (state == S_LINE && hs_rise && line_cnt != LINE_MAX)
        line_cnt <= line_cnt + YW'(1);
    end
  end

  always_comb begin
    in_frame    = (state == S_HBLANK || state == S_LINE) && (vs_i == VS_ACTIVE);
    line_active = in_frame && (hs_i == HS_ACTIVE) && (state == S_LINE || hs_fall);
    pix_idx     = (state == S_LINE) ? pix_cnt : '0;
    x_end       = {2'b00, x_start_q} + {1'b0, x_size_q};
    y_end       = {2'b00, y_start_q} + {1'b0, y_size_q};
    line_in_win = in_frame && (x_size_q != '0)
                  && ({2'b00, line_cnt} >= {2'b00, y_start_q})
                  && ({2'b00, line_cnt} < y_end);
    pix_in_win  = line_in_win && line_active && de_i
                  && ({2'b00, pix_idx} >= {2'b00, x_start_q})
                  && ({2'b00, pix_idx} < x_end);
    byp         = cfg_load ? bypass : bypass_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= ~HS_ACTIVE;
      vs_o <= ~VS_ACTIVE;
    end else if (state == S_WAIT) begin
      de_o <= 1'b0;
      hs_o <= ~HS_ACTIVE;
      vs_o <= ~VS_ACTIVE;
    end else if (byp) begin
      do_o <= di_i;
      de_o <= de_i;
      hs_o <= hs_i;
      vs_o <= vs_i;
    end else begin
      if (pix_in_win) do_o <= di_i;
      de_o <= pix_in_win;
      hs_o <= line_in_win ? hs_i : ~HS_ACTIVE;
      vs_o <= vs_i;
    end
  end

`ifdef VIDEO_CROP_STATUS_EN
  logic frame_end;
  assign frame_end = vs_fall && (state == S_HBLANK || state == S_LINE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_width  <= '0;
      in_height <= '0;
      crop_err  <= 1'b0;
    end else begin
      if (state == S_LINE && hs_rise) in_width <= pix_cnt;
      if (frame_end) begin
        in_height <= line_cnt;
        crop_err  <= (x_end > {2'b00, in_width}) || (y_end > {2'b00, line_cnt});
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_crop.sv
// Bench for video_crop: table of frame scenarios plus randomized frames,
// checked cycle by cycle against a geometry-based reference model.
module tb_video_crop;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bypass = 1'b0;
  logic [9:0]  crop_x_start = '0;
  logic [10:0] crop_x_size = '0;
  logic [9:0]  crop_y_start = '0;
  logic [10:0] crop_y_size = '0;
  logic [7:0]  di_i = '0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b1;
  logic        vs_i = 1'b0;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o;

  video_crop #(.PIXEL_WIDTH(8), .LINE_SIZE_MAX(1024), .FRAME_LINES_MAX(1024)) dut (
    .clk(clk), .rst(rst), .bypass(bypass),
    .crop_x_start(crop_x_start), .crop_x_size(crop_x_size),
    .crop_y_start(crop_y_start), .crop_y_size(crop_y_size),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int byp, w, h, xs, xsz, ys, ysz, sparse, ramp;
    int chg_line, chg_xsz, scramble, rst_line;
    int exp_de, exp_lines;   // -1: take from the reference model
  } frame_t;

  int errors = 0;
  int checks = 0;
  int cur_frame = 0;

  // reference model state: window as latched for the current frame
  bit frm_byp = 0;
  int frm_xs, frm_xsz, frm_ys, frm_ysz;
  bit suppress = 1;
  logic [7:0] exp_do = '0;

  int n_de_o, n_hs_fall, n_vs_rise, n_exp_de, n_exp_lines;
  logic prev_hs_o, prev_vs_o;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s frame=%0d t=%0t: got %0h want %0h", name, cur_frame, $time, got, want);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic de, input logic hs, input logic vs,
                      input bit keep_line, input bit keep_pix);
    logic [10:0] want;
    di_i = d; de_i = de; hs_i = hs; vs_i = vs;
    if (!vs) suppress = 0;
    if (suppress) begin
      want = {exp_do, 1'b0, 1'b1, 1'b0};
    end else if (frm_byp) begin
      exp_do = d;
      want = {d, de, hs, vs};
      if (de) n_exp_de++;
    end else begin
      if (keep_pix) begin exp_do = d; n_exp_de++; end
      want = {exp_do, keep_pix, (keep_line && !hs) ? 1'b0 : 1'b1, vs};
    end
    @(posedge clk); #1;
    check("cycle", {21'd0, do_o, de_o, hs_o, vs_o}, {21'd0, want});
    if (de_o) n_de_o++;
    if (prev_hs_o && !hs_o) n_hs_fall++;
    if (!prev_vs_o && vs_o) n_vs_rise++;
    prev_hs_o = hs_o;
    prev_vs_o = vs_o;
  endtask

  task automatic run_frame(input frame_t f);
    bit did_rst = 0;
    n_de_o = 0; n_hs_fall = 0; n_vs_rise = 0; n_exp_de = 0; n_exp_lines = 0;
    prev_hs_o = hs_o; prev_vs_o = vs_o;
    bypass = f.byp[0];
    crop_x_start = 10'(f.xs); crop_x_size = 11'(f.xsz);
    crop_y_start = 10'(f.ys); crop_y_size = 11'(f.ysz);
    for (int i = 0; i < 4; i++) step(8'($urandom), 1'b0, 1'b1, 1'b0, 0, 0);
    frm_byp = f.byp[0]; frm_xs = f.xs; frm_xsz = f.xsz; frm_ys = f.ys; frm_ysz = f.ysz;
    for (int i = 0; i < 3; i++) step(8'($urandom), 1'b0, 1'b1, 1'b1, 0, 0);
    for (int y = 0; y < f.h; y++) begin
      bit kept;
      int x;
      kept = (frm_xsz != 0) && (y >= frm_ys) && (y < frm_ys + frm_ysz);
      if (!suppress && (frm_byp || kept)) n_exp_lines++;
      if (y == f.chg_line) crop_x_size = 11'(f.chg_xsz);
      if (f.scramble != 0 && y == 1) begin
        bypass = 1'($urandom); crop_x_start = 10'($urandom); crop_x_size = 11'($urandom);
        crop_y_start = 10'($urandom); crop_y_size = 11'($urandom);
      end
      x = 0;
      while (x < f.w) begin
        logic de;
        logic [7:0] d;
        bit keep;
        de = (f.sparse != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        d = (de && f.ramp != 0) ? 8'(x) : 8'($urandom);
        keep = de && kept && (x >= frm_xs) && (x < frm_xs + frm_xsz);
        if (y == f.rst_line && x == 2 && !did_rst) begin
          rst = 1'b0;
          #1;
          check("reset_immediate", {21'd0, do_o, de_o, hs_o, vs_o}, {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
          suppress = 1; frm_byp = 0; exp_do = '0;
          n_de_o = 0; n_exp_de = 0;
          did_rst = 1;
        end
        step(d, de, 1'b0, 1'b1, kept, keep);
        if (!rst) rst = 1'b1;
        if (de) x++;
      end
      for (int i = 0; i < 3; i++) step(8'($urandom), 1'b0, 1'b1, 1'b1, kept, 0);
    end
    check("de_count", n_de_o, (f.exp_de < 0) ? n_exp_de : f.exp_de);
    check("kept_lines", n_hs_fall, (f.exp_lines < 0) ? n_exp_lines : f.exp_lines);
    check("vs_rise", n_vs_rise, 1);
    if (did_rst) check("post_reset_de", n_de_o, 0);
    cur_frame++;
  endtask

  frame_t tbl[12];

  initial begin
    //          byp w  h  xs xsz ys ysz sp ramp chg chgx scr rst  de lines
    tbl[0]  = '{1,  8, 4, 0, 0,  0, 0,  1, 0,  -1, 0,  0, -1,  -1, 4};
    tbl[1]  = '{0, 16, 8, 4, 6,  2, 3,  0, 1,  -1, 0,  0, -1,  18, 3};
    tbl[2]  = '{0, 16, 8, 12, 8, 0, 8,  0, 1,  -1, 0,  0, -1,  32, 8};
    tbl[3]  = '{0, 16, 8, 4, 6,  0, 8,  0, 1,   3, 2,  0, -1,  48, 8};
    tbl[4]  = '{0, 16, 8, 4, 2,  0, 8,  0, 1,  -1, 0,  0, -1,  16, 8};
    tbl[5]  = '{0, 16, 8, 0, 16, 0, 0,  0, 1,  -1, 0,  0, -1,   0, 0};
    tbl[6]  = '{0, 16, 8, 0, 0,  0, 8,  0, 1,  -1, 0,  0, -1,   0, 0};
    tbl[7]  = '{0, 16, 8, 0, 16, 6, 5,  0, 1,  -1, 0,  0, -1,  32, 2};
    tbl[8]  = '{0, 16, 8, 4, 6,  0, 8,  0, 1,  -1, 0,  0,  3,  -1, -1};
    tbl[9]  = '{0, 16, 8, 4, 6,  2, 3,  0, 1,  -1, 0,  0, -1,  18, 3};
    tbl[10] = '{0, 16, 8, 3, 5,  1, 4,  1, 0,  -1, 0,  0, -1,  -1, 4};
    tbl[11] = '{1,  8, 4, 0, 0,  0, 0,  0, 0,  -1, 0,  0, -1,  32, 4};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {21'd0, do_o, de_o, hs_o, vs_o}, {21'd0, 8'h00, 1'b0, 1'b1, 1'b0});
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_frame(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      frame_t f;
      f.byp = ($urandom_range(0, 7) == 0) ? 1 : 0;
      f.w = $urandom_range(4, 20); f.h = $urandom_range(2, 10);
      f.xs = $urandom_range(0, 24); f.xsz = $urandom_range(0, 24);
      f.ys = $urandom_range(0, 12); f.ysz = $urandom_range(0, 12);
      f.sparse = $urandom_range(0, 1); f.ramp = $urandom_range(0, 1);
      f.chg_line = -1; f.chg_xsz = 0; f.scramble = 1; f.rst_line = -1;
      f.exp_de = -1; f.exp_lines = -1;
      run_frame(f);
    end

    for (int i = 0; i < 3; i++) step(8'($urandom), 1'b0, 1'b1, 1'b0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_crop.md
# video_crop

Window-select stage upstream of the 2x2 binning filter. It takes the raw de/hs/vs pixel stream and forwards only a rectangular region of interest, regenerating hs/vs so the downstream binning stage sees a smaller, self-consistent frame. Window geometry and bypass are latched once per frame, so register writes never tear a frame.

## Interface
- PIXEL_WIDTH, 8, pixel data width
- LINE_SIZE_MAX, 1024, max pixels per input line; counter width is clog2(LINE_SIZE_MAX)
- FRAME_LINES_MAX, 1024, max lines per input frame; counter width is clog2(FRAME_LINES_MAX)
- clk  input  1  pixel clock; the only clock
- rst  input  1  reset, asynchronous, active-low
- bypass  input  1  1 = pass stream unmodified, with 1-cycle latency
- crop_x_start  input  clog2(LINE_SIZE_MAX)  first kept pixel index in a line
- crop_x_size  input  clog2(LINE_SIZE_MAX)+1  kept pixels per line; 0 = empty window
- crop_y_start  input  clog2(FRAME_LINES_MAX)  first kept line index
- crop_y_size  input  clog2(FRAME_LINES_MAX)+1  kept lines; 0 = empty window
- di_i  input  PIXEL_WIDTH  pixel data, valid when de_i=1
- de_i  input  1  pixel valid; may be sparse (gaps inside a line allowed)
- hs_i  input  1  0 during the active line, 1 during horizontal blanking
- vs_i  input  1  1 during the active frame, 0 during vertical blanking
- do_o, de_o, hs_o, vs_o  output  PIXEL_WIDTH/1/1/1  cropped stream; same polarities as the inputs

## Operation
- FSM states:
  - S_WAIT: after reset, wait for vs_i=0.
  - S_VBLANK: on a vs_i 0->1 edge, latch the crop_* and bypass inputs, clear line_cnt, go to S_HBLANK.
  - S_HBLANK: on hs_i 1->0, clear pix_cnt and go to S_LINE.
  - S_LINE: on hs_i 0->1, increment line_cnt and go to S_HBLANK.
  - vs_i=0 in any state except S_WAIT forces S_VBLANK.
- pix_cnt increments on each de_i=1 in S_LINE and saturates at LINE_SIZE_MAX-1.
- line_cnt saturates at FRAME_LINES_MAX-1.
- A line is in the window when y_start <= line_cnt < y_start+y_size. A pixel is in the window when the line is in the window and x_start <= pix_cnt < x_start+x_size.
- Window-end sums use one extra bit, so there is no wrap-around.
- Outputs:
  - de_o = de_i AND pixel-in-window.
  - do_o is updated only when de_o=1 and holds its value otherwise.
  - hs_o = hs_i on in-window lines, forced to 1 on other lines.
  - vs_o = vs_i.
- A window extending past the input line or frame is truncated; no error is raised and no padding is added.
- x_size=0 or y_size=0: no de_o, and hs_o stays at 1 for the whole frame; vs_o still toggles.
- With latched bypass=1, all outputs are the inputs delayed by exactly one cycle.
- crop_* or bypass changes mid-frame take effect at the next vs_i rising edge only.
- Reset mid-frame: outputs go to their reset values immediately and the FSM enters S_WAIT. The block does not resume a partial frame.

## Timing
- Latency: 1 clk from input to output for all signals, crop or bypass alike.
- Reset values: do_o=0, de_o=0, hs_o=1, vs_o=0.
- Sparse-de input: output gaps match input gaps cycle for cycle; no re-timing.
- hs_o falls on the same relative cycle as hs_i for kept lines, so downstream line-edge detection works unchanged.
- Config inputs are sampled in the cycle where vs_i goes 0->1. They must be stable in that cycle.

## Configuration
- VIDEO_CROP_STATUS_EN adds these outputs:
  - in_width: pix_cnt captured at each line end.
  - in_height: line_cnt captured at each frame end.
  - crop_err: sticky flag, set when the latched window exceeds the measured input. Cleared by reset or by a frame with a valid window.
- Without the macro, these ports and their registers are absent; crop behaviour is identical either way.

## Structure
- Shared video package holds:
  - FSM state typedef (S_WAIT, S_VBLANK, S_HBLANK, S_LINE).
  - Polarity constants: HS_ACTIVE=0, VS_ACTIVE=1.
- One sub-module, video_sync_edge: registers hs_i and vs_i and provides their rise/fall pulses. It is reused by the binning and scaler stages.

## Test plan
- bypass=1, 8x4 frame, de_sparse=1 -> outputs equal inputs delayed 1 clk, bit-exact.
- 16x8 frame, ramp pixel data = x, window x_start=4, x_size=6, y_start=2, y_size=3 -> 3 lines with hs_o=0, each with 6 de_o; data 4..9; the other 5 lines have hs_o=1 and no de_o.
- x_start=12, x_size=8 on a 16-wide input -> 4 pixels per line (12..15), no extras.
- Change x_size 6->2 mid-frame -> current frame keeps 6 pixels per line; next frame gives 2.
- y_size=0 -> vs_o toggles, hs_o stays 1, de_o stays 0 for the whole frame.
- Assert rst low for 1 cycle at line 3 -> outputs reset at once; rest of that frame suppressed; next full frame cropped correctly.
